// File: rtl/wca_dsp_pkg.sv
// rtl/wca_dsp_pkg.sv - shared DSP counter/capture defaults
package wca_dsp_pkg;

   // Counter MSB index; count buses are WCA_DSP_MAXBITS+1 bits wide.
   localparam int WCA_DSP_MAXBITS       = 24;
   // Capture FIFO holds 2**WCA_CAPTURE_DEPTH_LOG2 entries.
   localparam int WCA_CAPTURE_DEPTH_LOG2 = 2;

endpackage

// File: rtl/wca_dsp_sync_fifo.sv
// rtl/wca_dsp_sync_fifo.sv - show-ahead single-clock FIFO with explicit level
module wca_dsp_sync_fifo #(
   parameter int WIDTH      = 25,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  rd_valid,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_pop;
   logic                  do_push;

   // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
   // when a pop frees the head slot in the same cycle.
   assign rd_valid = (level != '0);
   assign full     = (level == LW'(DEPTH));
   assign do_pop   = pop & rd_valid;
   assign do_push  = push & (~full | do_pop);
   assign rd_data  = mem[rd_ptr];

   // Storage, pointers (wrap naturally) and the independently tracked level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/wca_dsp_count_capture.sv
// rtl/wca_dsp_count_capture.sv - trigger-edge capture of the DSP counter value
module wca_dsp_count_capture
   import wca_dsp_pkg::*;
#(
   parameter int MAXBITS    = WCA_DSP_MAXBITS,
   parameter int DEPTH_LOG2 = WCA_CAPTURE_DEPTH_LOG2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [MAXBITS:0]      count,
   input  logic                  enable,
   input  logic                  trigger,
   input  logic                  rd_req,
   input  logic                  clear_ovf,
   output logic [MAXBITS:0]      rd_data,
   output logic                  rd_valid,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow
);

   logic trig_d;
   logic trig_edge;
   logic full;
   logic drop;

   // Enable gates the edge itself, so a trigger already high when enable
   // rises produces no capture.
   assign trig_edge = trigger & ~trig_d & enable;
   // A capture is lost only when full and the head is not popped this cycle.
   assign drop      = trig_edge & full & ~(rd_req & rd_valid);

   // Trigger history; resets high so a trigger held through reset is not an edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) trig_d <= 1'b1;
      else       trig_d <= trigger;
   end

   // Sticky overflow; a drop in the same cycle as clear_ovf keeps it set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)          overflow <= 1'b0;
      else if (drop)      overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
   end

   wca_dsp_sync_fifo #(
      .WIDTH      (MAXBITS + 1),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (trig_edge),
      .push_data (count),
      .pop       (rd_req),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .level     (level),
      .full      (full)
   );

endmodule

// File: tb/tb_wca_dsp_count_capture.sv
// tb/tb_wca_dsp_count_capture.sv - bench for wca_dsp_count_capture
module tb_wca_dsp_count_capture;

   logic        clock = 1'b0;
   logic        reset;
   logic [24:0] count;
   logic        enable;
   logic        trigger;
   logic        rd_req;
   logic        clear_ovf;
   logic [24:0] rd_data;
   logic        rd_valid;
   logic [2:0]  level;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        trig;
      logic [24:0] cnt;
      logic        rd;
      logic        clr;
      logic        en;
      logic        ev;
      logic [24:0] ed;
      logic [2:0]  el;
      logic        eo;
   } vec_t;

   vec_t vecs[$];

   wca_dsp_count_capture dut (
      .clock     (clock),
      .reset     (reset),
      .count     (count),
      .enable    (enable),
      .trigger   (trigger),
      .rd_req    (rd_req),
      .clear_ovf (clear_ovf),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic trig, input logic [24:0] cnt, input logic rd,
                               input logic clr, input logic ev, input logic [24:0] ed,
                               input logic [2:0] el, input logic eo);
      vec_t v;
      v.trig = trig; v.cnt = cnt; v.rd = rd; v.clr = clr; v.en = 1'b1;
      v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
      vecs.push_back(v);
   endfunction

   initial begin
      // trig, cnt, rd, clr | valid, data, level, ovf
      add(1, 10, 0, 0,  1, 10, 1, 0);
      add(0, 11, 0, 0,  1, 10, 1, 0);
      add(1, 20, 0, 0,  1, 10, 2, 0);
      add(0,  0, 0, 0,  1, 10, 2, 0);
      add(1, 30, 0, 0,  1, 10, 3, 0);
      add(0,  0, 0, 0,  1, 10, 3, 0);
      add(0,  0, 1, 0,  1, 20, 2, 0);
      add(0,  0, 1, 0,  1, 30, 1, 0);
      add(0,  0, 1, 0,  0,  0, 0, 0);
      add(1,  1, 0, 0,  1,  1, 1, 0);
      add(0,  0, 0, 0,  1,  1, 1, 0);
      add(1,  2, 0, 0,  1,  1, 2, 0);
      add(0,  0, 0, 0,  1,  1, 2, 0);
      add(1,  3, 0, 0,  1,  1, 3, 0);
      add(0,  0, 0, 0,  1,  1, 3, 0);
      add(1,  4, 0, 0,  1,  1, 4, 0);
      add(0,  0, 0, 0,  1,  1, 4, 0);
      add(1,  5, 0, 0,  1,  1, 4, 1);
      add(0,  0, 0, 0,  1,  1, 4, 1);
      add(1,  6, 0, 1,  1,  1, 4, 1);
      add(0,  0, 0, 1,  1,  1, 4, 0);
      add(1, 25'h1FFFFFF, 1, 0,  1, 2, 4, 0);
      add(0,  0, 1, 0,  1,  3, 3, 0);
      add(0,  0, 1, 0,  1,  4, 2, 0);
      add(0,  0, 1, 0,  1, 25'h1FFFFFF, 1, 0);
      add(0,  0, 1, 0,  0,  0, 0, 0);

      reset = 1'b1; trigger = 1'b1; enable = 1'b1; count = 25'h100;
      rd_req = 1'b0; clear_ovf = 1'b0;
      #1;
      chk("reset_valid", 32'(rd_valid), 0);
      chk("reset_level", 32'(level), 0);
      chk("reset_ovf", 32'(overflow), 0);
      chk("reset_data", 32'(rd_data), 0);
      tick(); tick();
      reset = 1'b0;

      // trigger held high through reset release: no capture
      for (int c = 'h100; c <= 'h110; c++) begin
         count = 25'(c);
         tick();
         chk("spur_valid", 32'(rd_valid), 0);
         chk("spur_level", 32'(level), 0);
      end
      trigger = 1'b0; tick();
      trigger = 1'b1; count = 25'h105; tick();
      chk("first_valid", 32'(rd_valid), 1);
      chk("first_data", 32'(rd_data), 32'h105);
      chk("first_level", 32'(level), 1);
      trigger = 1'b0; rd_req = 1'b1; tick();
      chk("first_pop_valid", 32'(rd_valid), 0);
      rd_req = 1'b0;

      foreach (vecs[i]) begin
         trigger = vecs[i].trig; count = vecs[i].cnt; rd_req = vecs[i].rd;
         clear_ovf = vecs[i].clr; enable = vecs[i].en;
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].ev));
         chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].el));
         chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].eo));
         if (vecs[i].ev) chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].ed));
      end
      trigger = 1'b0; rd_req = 1'b0; clear_ovf = 1'b0;

      // enable low: edges ignored, then enable rising with trigger high ignored
      enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         trigger = 1'b1; count = 25'(50 + k); tick();
         trigger = 1'b0; tick();
      end
      trigger = 1'b1; tick();
      chk("gated_level", 32'(level), 0);
      enable = 1'b1; tick(); tick();
      chk("enable_rise_level", 32'(level), 0);
      chk("enable_rise_valid", 32'(rd_valid), 0);
      trigger = 1'b0; tick();

      // 20 push/pop pairs walk the pointers around several times
      for (int k = 0; k < 20; k++) begin
         trigger = 1'b1; count = 25'(25'h0ABC00 + k); tick();
         chk($sformatf("wrap%0d_data", k), 32'(rd_data), 32'(25'h0ABC00 + k));
         chk($sformatf("wrap%0d_level", k), 32'(level), 1);
         trigger = 1'b0; rd_req = 1'b1; tick();
         rd_req = 1'b0;
         chk($sformatf("wrap%0d_empty", k), 32'(rd_valid), 0);
      end

      // fill, overflow, pop one, then asynchronous reset mid-cycle
      for (int k = 1; k <= 5; k++) begin
         trigger = 1'b1; count = 25'(100 + k); tick();
         trigger = 1'b0; tick();
      end
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      chk("pre_reset_level", 32'(level), 3);
      chk("pre_reset_ovf", 32'(overflow), 1);
      chk("pre_reset_data", 32'(rd_data), 102);
      #3 reset = 1'b1;
      #1;
      chk("async_reset_level", 32'(level), 0);
      chk("async_reset_valid", 32'(rd_valid), 0);
      chk("async_reset_ovf", 32'(overflow), 0);
      #1 reset = 1'b0;
      tick();
      trigger = 1'b1; count = 25'h0777; tick();
      chk("post_reset_data", 32'(rd_data), 32'h777);
      chk("post_reset_level", 32'(level), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wca_dsp_count_capture.md
# wca_dsp_count_capture

Event-driven capture block that reads the running value of a DSP counter on trigger edges and buffers the captured values for later readout. It sits downstream of the loadable up/down DSP counter: the counter produces a count, and this block samples that count on events such as PPS, packet start or gain change. It presents the samples through a show-ahead FIFO read port to the host register or streaming logic. It is the consumer end of the counter's `count` bus.

## Interface
- `MAXBITS`, 24 — counter MSB index; the count bus is MAXBITS+1 bits (25 by default), matching the DSP counter.
- `DEPTH_LOG2`, 2 — FIFO depth is 2^DEPTH_LOG2 entries (4 by default).

- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `count`  in  MAXBITS+1  running counter value, synchronous to `clock`.
- `enable`  in  1  (1) trigger edges are captured; (0) trigger edges are ignored.
- `trigger`  in  1  event input, already synchronous; a rising edge requests a capture.
- `rd_req`  in  1  pops the head entry when `rd_valid` is 1.
- `clear_ovf`  in  1  clears the sticky `overflow` flag.
- `rd_data`  out  MAXBITS+1  head-of-FIFO captured count (show-ahead).
- `rd_valid`  out  1  FIFO non-empty.
- `level`  out  DEPTH_LOG2+1  number of stored entries, 0..2^DEPTH_LOG2.
- `overflow`  out  1  sticky; a capture was dropped because the FIFO was full.

## Operation
- `trig_d` is a registered copy of `trigger` and is updated every cycle regardless of `enable`.
- edge = `trigger` & ~`trig_d` & `enable`. This term is combinational.
- On an edge, the `count` value present in that same cycle is written to the FIFO tail.
- Full and no pop in the same cycle: the capture is dropped, `overflow` is set, and FIFO contents are unchanged.
- Full with a pop in the same cycle: the pop and the push both occur, `level` stays at full, and `overflow` is not set.
- Empty with `rd_req` asserted: the request is ignored. A simultaneous push still occurs.
- `clear_ovf` and a drop in the same cycle: set wins, and `overflow` stays 1.
- Pointers wrap modulo 2^DEPTH_LOG2. `level` is tracked explicitly and is not derived from pointer difference.
- `rd_data` is undefined when `rd_valid` is 0. It holds the last head value and must not be relied on.
- No state machine beyond the FIFO pointers, the edge register and the overflow flag.

## Timing
- Reset values:
  - `rd_valid` = 0, `level` = 0, `overflow` = 0, `rd_data` = 0.
  - Read and write pointers = 0.
  - `trig_d` = 1, so a `trigger` held high through reset deassertion does not capture.
- Capture latency: for an edge in cycle n, the entry holds `count` as sampled at the end of cycle n. If the FIFO was empty, `rd_valid` = 1 and `rd_data` = that value in cycle n+1.
- Pop: `rd_req` & `rd_valid` in cycle n advances the head. The new `rd_data`, `level` and `rd_valid` are visible in cycle n+1.
- Throughput: a trigger period of 2 cycles (0,1,0,1) gives one capture every 2 cycles. One push and one pop are possible per cycle.
- `trigger` held high produces exactly one capture.
- Reset asserted mid-operation clears the FIFO and the flag immediately (asynchronous). Buffered entries are lost.
- `enable` dropping in the edge cycle suppresses that capture. A trigger already high when `enable` rises does not capture.

## Structure
- Shared package `wca_dsp_pkg` holds the defaults `WCA_DSP_MAXBITS` = 24 and `WCA_CAPTURE_DEPTH_LOG2` = 2, reused by the counter and the capture blocks.
- Sub-module `wca_dsp_sync_fifo`: show-ahead, single-clock, parameterised width and depth. It takes push/pop and outputs data, valid, level and full.
- The top level contains the edge detect, the push/drop/overflow logic and port wiring.
- Target size: about 150–250 lines total.

## Test plan
- **Reset and spurious-edge check.** Hold `trigger` = 1 through `reset` release, then drive `count` 0x000100..0x000110 → `rd_valid` stays 0 and `level` stays 0. Then drive `trigger` 0 then 1 with `count` = 0x000105 → next cycle `rd_valid` = 1, `rd_data` = 0x000105.
- **Latency and ordering.** With `enable` = 1, apply edges at counts 10, 20, 30, then pop three times → `rd_data` sequence 10, 20, 30, with `level` stepping 3, 2, 1, 0 and `rd_valid` low after the last pop.
- **Overflow.** Capture 5 edges (counts 1..5) with no reads → `level` = 4, `overflow` = 1, and reads return 1, 2, 3, 4. `clear_ovf` then gives `overflow` = 0.
- **Full boundary.** Full with a simultaneous edge (count 0x1FFFFFF) and `rd_req` → `level` stays 4, `overflow` stays 0, and the last read returns 0x1FFFFFF (full-width value).
- **Gating, wrap and reset.**
  - With `enable` = 0, 10 edges → no entries.
  - 20 push/pop pairs → pointer wrap with correct data.
  - Assert `reset` mid-stream with `level` = 3 → `level` = 0, `rd_valid` = 0 and `overflow` = 0 asynchronously.
- **Set-wins priority.** `clear_ovf` in the same cycle as a drop → `overflow` remains 1.
